jtkiwi_vram_tdm: RTL



---
 rtl/jtkiwi_vram_tdm.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/jtkiwi_vram_tdm.sv
// Time-division arbiter sharing one synchronous single-port VRAM between CH graphics channels and a CPU.
// Optional macro JTKIWI_TDM_STEAL_EN lets a waiting CPU access use graphics slots whose owner is idle.
module jtkiwi_vram_tdm #(
    parameter int CH    = 2,
    parameter int SPC   = 2,
    parameter int CPUS  = 1,
    parameter int AW    = 12,
    parameter int DW    = 16,
    parameter int RDLAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CH*AW-1:0]   gfx_addr,
    input  logic [CH-1:0]      gfx_idle,
    output logic [CH-1:0]      gfx_cen,
    output logic [CH*DW-1:0]   gfx_data,
    output logic [CH-1:0]      gfx_dok,
    input  logic               cpu_cs,
    input  logic               cpu_rnw,
    input  logic [AW-1:0]      cpu_addr,
    input  logic [DW-1:0]      cpu_dout,
    input  logic [DW/8-1:0]    cpu_wmask,
    output logic [DW-1:0]      cpu_din,
    output logic               cpu_ok,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    output logic [DW/8-1:0]    ram_we,
    input  logic [DW-1:0]      ram_dout
);

    localparam int L  = CH * SPC + CPUS;
    localparam int GS = CH * SPC;
    localparam int SW = (L > 1) ? $clog2(L) : 1;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int LW = (RDLAT > 1) ? $clog2(RDLAT) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StRdWait, StDone} cpu_st_e;

    cpu_st_e           r_state, w_state_nxt;
    logic [SW-1:0]     r_slot, w_slot_nxt;
    logic              r_run;
    logic [CH-1:0]     r_gfx_cen;
    logic [CH*DW-1:0]  r_gfx_data;
    logic [CH-1:0]     r_gfx_dok;
    logic [RDLAT-1:0]  r_dl_vld;
    logic [CW-1:0]     r_dl_own [RDLAT];
    logic              r_supp;
    logic              r_used;
    logic [LW-1:0]     r_cnt;
    logic [DW-1:0]     r_cpu_din;
    logic              r_cpu_ok;

    logic              w_last, w_gfx_slot, w_owner_last;
    logic [CW-1:0]     w_owner;
    logic              w_steal_ok, w_slot_ok, w_issue, w_stolen;
    logic              w_push_pt, w_push;

    assign w_last     = (r_slot == SW'(L - 1));
    assign w_gfx_slot = (r_slot < SW'(GS));
    // Slot stays at 0 for the one idle cycle after reset so the first frame starts cleanly.
    assign w_slot_nxt = (!r_run || w_last) ? '0 : r_slot + 1'b1;

    always_comb begin
        w_owner      = '0;
        w_owner_last = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (r_slot >= SW'(k * SPC) && r_slot < SW'(k * SPC + SPC)) begin
                w_owner      = CW'(k);
                w_owner_last = (r_slot == SW'(k * SPC + SPC - 1));
            end
        end
    end

`ifdef JTKIWI_TDM_STEAL_EN
    assign w_steal_ok = r_run && w_gfx_slot && gfx_idle[w_owner];
`else
    logic w_unused_idle;
    assign w_unused_idle = ^gfx_idle;
    assign w_steal_ok    = 1'b0;
`endif

    assign w_slot_ok = !r_used && ((r_run && !w_gfx_slot) || w_steal_ok);
    assign w_stolen  = w_issue && w_gfx_slot;
    assign w_push_pt = r_run && w_gfx_slot && w_owner_last;
    assign w_push    = w_push_pt && !(r_supp || w_stolen);

    always_comb begin
        ram_addr = cpu_addr;
        if (w_gfx_slot && !w_stolen) ram_addr = gfx_addr[int'(w_owner) * AW +: AW];
    end

    assign ram_din  = cpu_dout;
    assign gfx_cen  = r_gfx_cen;
    assign gfx_data = r_gfx_data;
    assign gfx_dok  = r_gfx_dok;
    assign cpu_din  = r_cpu_din;
    assign cpu_ok   = r_cpu_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot    <= '0;
            r_run     <= 1'b0;
            r_gfx_cen <= '0;
        end else begin
            r_run  <= 1'b1;
            r_slot <= w_slot_nxt;
            for (int k = 0; k < CH; k++) r_gfx_cen[k] <= (w_slot_nxt == SW'(k * SPC));
        end
    end

    // Owner delay line: one entry per in-flight graphics read, aligned to RAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dl_vld   <= '0;
            for (int i = 0; i < RDLAT; i++) r_dl_own[i] <= '0;
            r_gfx_data <= '0;
            r_gfx_dok  <= '0;
            r_supp     <= 1'b0;
        end else begin
            r_dl_vld[0] <= w_push;
            r_dl_own[0] <= w_owner;
            for (int i = 1; i < RDLAT; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_own[i] <= r_dl_own[i-1];
            end
            for (int k = 0; k < CH; k++) begin
                r_gfx_dok[k] <= r_dl_vld[RDLAT-1] && (r_dl_own[RDLAT-1] == CW'(k));
                if (r_dl_vld[RDLAT-1] && (r_dl_own[RDLAT-1] == CW'(k)))
                    r_gfx_data[k*DW +: DW] <= ram_dout;
            end
            if (w_push_pt)     r_supp <= 1'b0;
            else if (w_stolen) r_supp <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:   if (cpu_cs) w_state_nxt = StWait;
            StWait: begin
                if (!cpu_cs)        w_state_nxt = StIdle;
                else if (w_slot_ok) w_state_nxt = cpu_rnw ? StRdWait : StDone;
            end
            StRdWait: begin
                if (!cpu_cs)          w_state_nxt = StIdle;
                else if (r_cnt == '0) w_state_nxt = StDone;
            end
            StDone:   if (!cpu_cs) w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_issue = 1'b0;
        ram_we  = '0;
        if (r_state == StWait && cpu_cs && w_slot_ok) begin
            w_issue = 1'b1;
            if (!cpu_rnw) ram_we = cpu_wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_cpu_din <= '0;
            r_cpu_ok  <= 1'b0;
            r_used    <= 1'b0;
        end else begin
            r_cpu_ok <= (r_state != StDone) && (w_state_nxt == StDone);
            if (r_run && w_last) r_used <= 1'b0;
            else if (w_issue)    r_used <= 1'b1;
            if (w_issue)
                r_cnt <= LW'(RDLAT - 1);
            else if (r_state == StRdWait && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            if (r_state == StRdWait && cpu_cs && r_cnt == '0) r_cpu_din <= ram_dout;
        end
    end

endmodule
